// File: rtl/ov7670_pkg.sv
// Shared types and helpers for the OV7670 pixel capture block.
package ov7670_pkg;

  // Decimation factor applied to both axes.
  typedef enum logic [1:0] {
    Decim1 = 2'd0,
    Decim2 = 2'd1,
    Decim4 = 2'd2,
    Decim8 = 2'd3
  } decim_e;

  // Output pixel format.
  typedef enum logic {
    FmtRgb565 = 1'b0,
    FmtRgb444 = 1'b1
  } fmt_e;

  // Capture sequencer states.
  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWaitVs    = 2'd1,
    StWaitFrame = 2'd2,
    StCapture   = 2'd3
  } cap_state_e;

  // RGB565 word -> {4'h0, R[4:1], G[5:2], B[4:1]}.
  function automatic logic [15:0] pack_rgb444(input logic [15:0] w);
    return {4'h0, w[15:12], w[10:7], w[4:1]};
  endfunction

  // Low-bit mask selecting px/ln positions that must be zero to keep a word.
  function automatic logic [2:0] decim_mask(input decim_e dc);
    logic [2:0] m;
    unique case (dc)
      Decim1:  m = 3'b000;
      Decim2:  m = 3'b001;
      Decim4:  m = 3'b011;
      Decim8:  m = 3'b111;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ov7670_capture_px_if.sv
// Camera input bus plus frame-buffer write port and status of the capture block.
interface ov7670_capture_px_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              vsync;
  logic              href;
  logic [7:0]        d;
  logic [1:0]        decim;
  logic              fmt;
  logic              arm;
  logic              continuous;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       dout;
  logic              we;
  logic              busy;
  logic              frame_done;
  logic              overflow;
  logic              byte_err;

  // Camera / controller side.
  modport master (
    output vsync, href, d, decim, fmt, arm, continuous,
    input  addr, dout, we, busy, frame_done, overflow, byte_err
  );

  // Capture block side.
  modport slave (
    input  vsync, href, d, decim, fmt, arm, continuous,
    output addr, dout, we, busy, frame_done, overflow, byte_err
  );
endinterface

// File: rtl/ov7670_byte_pair.sv
// Assembles href-qualified byte pairs into 16-bit words; flags a dangling odd byte.
module ov7670_byte_pair (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        href_i,
  input  logic [7:0]  d_i,
  output logic [15:0] word_o,
  output logic        word_valid_o,
  output logic        odd_err_o
);

  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        odd_q, odd_d;

  // Pairing: first byte of a pair is the high byte; disabling drops any half word.
  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    word_d  = word_q;
    valid_d = 1'b0;
    odd_d   = 1'b0;
    if (!en_i) begin
      phase_d = 1'b0;
    end else if (href_i) begin
      if (!phase_q) begin
        hi_d    = d_i;
        phase_d = 1'b1;
      end else begin
        word_d  = {hi_q, d_i};
        valid_d = 1'b1;
        phase_d = 1'b0;
      end
    end else if (phase_q) begin
      odd_d   = 1'b1;
      phase_d = 1'b0;
    end
  end

  // Pairing state and registered word strobe.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
      word_q  <= 16'h0000;
      valid_q <= 1'b0;
      odd_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      odd_q   <= odd_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign odd_err_o    = odd_q;

endmodule

// File: rtl/ov7670_capture_px.sv
// OV7670 frame capture: frame sequencing, decimation, formatting and buffer writes.
module ov7670_capture_px
  import ov7670_pkg::*;
#(
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned H_PIX   = 640,
  parameter int unsigned V_LINES = 480,
  parameter int unsigned DEPTH   = 76800
) (
  input logic           pclk,
  input logic           rst_n,
  ov7670_capture_px_if.slave cam
);

  localparam int unsigned PxW  = $clog2(H_PIX + 1);
  localparam int unsigned LnW  = $clog2(V_LINES + 2);
  localparam int unsigned CntW = ADDR_W + 1;

  localparam logic [PxW-1:0]  HPixL   = PxW'(H_PIX);
  localparam logic [LnW-1:0]  VLinesL = LnW'(V_LINES);
  localparam logic [LnW-1:0]  LnSat   = LnW'(V_LINES + 1);
  localparam logic [CntW-1:0] DepthL  = CntW'(DEPTH);

  // Registered camera inputs plus one-cycle history for edge detection.
  logic       vs_q, vs_prev_q, href_q, href_prev_q;
  logic [7:0] d_q;

  cap_state_e        state_q, state_d;
  decim_e            decim_q, decim_d;
  fmt_e              fmt_q, fmt_d;
  logic [PxW-1:0]    px_q, px_d;
  // Count of href rises this frame; line index is this minus one.
  logic [LnW-1:0]    ln_q, ln_d;
  logic [CntW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dout_q, dout_d;
  logic              we_q, we_d;
  logic              fd_q, fd_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic [15:0] word;
  logic        word_valid, odd_err;
  logic        vs_rise, vs_fall, href_rise;
  logic [LnW-1:0] ln_idx;
  logic [2:0]  mask;
  logic        in_range, keep;

  // Input registers: all camera signals are sampled once before any use.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      d_q         <= 8'h00;
    end else begin
      vs_q        <= cam.vsync;
      vs_prev_q   <= vs_q;
      href_q      <= cam.href;
      href_prev_q <= href_q;
      d_q         <= cam.d;
    end
  end

  ov7670_byte_pair u_byte_pair (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .en_i         (state_q == StCapture),
    .href_i       (href_q),
    .d_i          (d_q),
    .word_o       (word),
    .word_valid_o (word_valid),
    .odd_err_o    (odd_err)
  );

  assign vs_rise   = vs_q & ~vs_prev_q;
  assign vs_fall   = ~vs_q & vs_prev_q;
  assign href_rise = href_q & ~href_prev_q;
  assign ln_idx    = ln_q - LnW'(1);
  assign mask      = decim_mask(decim_q);
  assign in_range  = (px_q < HPixL) && (ln_q != '0) && (ln_q <= VLinesL);
  assign keep      = ((3'(px_q) & mask) == 3'd0) && ((3'(ln_idx) & mask) == 3'd0);

  // Sequencer, pixel/line counting, decimation and write-port generation.
  always_comb begin
    state_d  = state_q;
    decim_d  = decim_q;
    fmt_d    = fmt_q;
    px_d     = px_q;
    ln_d     = ln_q;
    wr_cnt_d = wr_cnt_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    we_d     = 1'b0;
    fd_d     = 1'b0;
    ovf_d    = ovf_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (cam.arm || cam.continuous) state_d = StWaitVs;
      end
      StWaitVs: begin
        if (vs_q) state_d = StWaitFrame;
      end
      StWaitFrame: begin
        if (vs_fall) begin
          state_d  = StCapture;
          decim_d  = decim_e'(cam.decim);
          fmt_d    = fmt_e'(cam.fmt);
          px_d     = '0;
          ln_d     = '0;
          wr_cnt_d = '0;
          addr_d   = '0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
        end
      end
      StCapture: begin
        if (vs_rise) begin
          // Frame end wins over any word completing this cycle.
          fd_d    = 1'b1;
          state_d = cam.continuous ? StWaitFrame : StIdle;
        end else begin
          if (href_rise) begin
            px_d = '0;
            if (ln_q != LnSat) ln_d = ln_q + LnW'(1);
          end
          if (odd_err) err_d = 1'b1;
          if (word_valid) begin
            if (!in_range) begin
              err_d = 1'b1;
            end else begin
              px_d = px_q + PxW'(1);
              if (keep) begin
                if (wr_cnt_q == DepthL) begin
                  ovf_d = 1'b1;
                end else begin
                  we_d     = 1'b1;
                  addr_d   = wr_cnt_q[ADDR_W-1:0];
                  dout_d   = (fmt_q == FmtRgb444) ? pack_rgb444(word) : word;
                  wr_cnt_d = wr_cnt_q + CntW'(1);
                end
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer and output state.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      decim_q  <= Decim1;
      fmt_q    <= FmtRgb565;
      px_q     <= '0;
      ln_q     <= '0;
      wr_cnt_q <= '0;
      addr_q   <= '0;
      dout_q   <= 16'h0000;
      we_q     <= 1'b0;
      fd_q     <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      decim_q  <= decim_d;
      fmt_q    <= fmt_d;
      px_q     <= px_d;
      ln_q     <= ln_d;
      wr_cnt_q <= wr_cnt_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      we_q     <= we_d;
      fd_q     <= fd_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign cam.addr       = addr_q;
  assign cam.dout       = dout_q;
  assign cam.we         = we_q;
  assign cam.busy       = (state_q != StIdle);
  assign cam.frame_done = fd_q;
  assign cam.overflow   = ovf_q;
  assign cam.byte_err   = err_q;

endmodule

// File: tb/tb_ov7670_capture_px.sv
// Scoreboard bench: two capture instances (deep and shallow buffer) share one camera stream.
module tb_ov7670_capture_px;

  localparam int AW = 6;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int DA = 64;
  localparam int DB = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       vsync, href, arm, continuous, fmt;
  logic [7:0] d;
  logic [1:0] decim;

  always #5 pclk = ~pclk;

  ov7670_capture_px_if #(.ADDR_W(AW)) if_a ();
  ov7670_capture_px_if #(.ADDR_W(AW)) if_b ();

  assign if_a.vsync = vsync;  assign if_b.vsync = vsync;
  assign if_a.href  = href;   assign if_b.href  = href;
  assign if_a.d     = d;      assign if_b.d     = d;
  assign if_a.decim = decim;  assign if_b.decim = decim;
  assign if_a.fmt   = fmt;    assign if_b.fmt   = fmt;
  assign if_a.arm   = arm;    assign if_b.arm   = arm;
  assign if_a.continuous = continuous;
  assign if_b.continuous = continuous;

  ov7670_capture_px #(.ADDR_W(AW), .H_PIX(H), .V_LINES(V), .DEPTH(DA)) u_dut_a (
    .pclk  (pclk),
    .rst_n (rst_n),
    .cam   (if_a)
  );

  ov7670_capture_px #(.ADDR_W(AW), .H_PIX(H), .V_LINES(V), .DEPTH(DB)) u_dut_b (
    .pclk  (pclk),
    .rst_n (rst_n),
    .cam   (if_b)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  wr_t         qa[$];
  wr_t         qb[$];
  int          fd_a = 0, fd_b = 0;
  logic [15:0] first_dout_a = 16'h0;
  logic [7:0]  fb[$];
  int          ll[$];
  bit          abort_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rgb444(input logic [15:0] w);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = w[15:11];
    g = w[10:5];
    b = w[4:0];
    return {4'h0, r[4:1], g[5:2], b[4:1]};
  endfunction

  task automatic mon_write(input int which, input logic [AW-1:0] a, input logic [15:0] dat);
    wr_t e;
    if ((which == 0 && qa.size() == 0) || (which == 1 && qb.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_we dut=%0d: got addr=0x%0h data=0x%0h want no write", which, a,
               dat);
    end else begin
      if (which == 0) e = qa.pop_front();
      else e = qb.pop_front();
      check(which == 0 ? "wr_addr_a" : "wr_addr_b", 32'(a), 32'(e.addr));
      check(which == 0 ? "wr_data_a" : "wr_data_b", 32'(dat), 32'(e.data));
    end
    if (which == 0 && a == '0) first_dout_a = dat;
  endtask

  // Monitor: pops the scoreboard whenever either instance writes.
  always @(negedge pclk) begin
    if (if_a.we) mon_write(0, if_a.addr, if_a.dout);
    if (if_b.we) mon_write(1, if_b.addr, if_b.dout);
    if (if_a.frame_done) fd_a++;
    if (if_b.frame_done) fd_b++;
  end

  task automatic fill_bytes();
    fb.delete();
    foreach (ll[l]) for (int b = 0; b < ll[l]; b++) fb.push_back(8'($urandom));
  endtask

  task automatic gen_frame(input int nlines, input bit allow_bad, input bit ab);
    ll.delete();
    abort_last = ab;
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = 2 * H;
      if (allow_bad) begin
        case ($urandom_range(0, 5))
          0: len = 2 * H - 1;
          1: len = 2 * H + 2;
          2: len = 6;
          default: len = 2 * H;
        endcase
      end
      if (ab && l == nlines - 1) len = 8;
      ll.push_back(len);
    end
    fill_bytes();
  endtask

  // Reference: the expected buffer contents follow from the byte stream directly.
  task automatic model_frame(input int dec, input bit fm, input int cut_line,
                             output bit ovf_a, output bit ovf_b, output bit err);
    int          idx, n, step;
    logic [15:0] w;
    wr_t         e;
    idx  = 0;
    n    = 0;
    step = 1 << dec;
    err  = 1'b0;
    for (int l = 0; l < ll.size(); l++) begin
      int nw;
      if (cut_line >= 0 && l >= cut_line) break;
      nw = ll[l] / 2;
      if (abort_last && l == ll.size() - 1) nw = nw - 1;
      else if (ll[l] % 2 != 0) err = 1'b1;
      for (int p = 0; p < nw; p++) begin
        w = {fb[idx + 2 * p], fb[idx + 2 * p + 1]};
        if (l >= V || p >= H) begin
          err = 1'b1;
        end else if (l % step == 0 && p % step == 0) begin
          e.addr = AW'(n);
          e.data = fm ? rgb444(w) : w;
          if (n < DA) qa.push_back(e);
          if (n < DB) qb.push_back(e);
          n++;
        end
      end
      idx += ll[l];
    end
    ovf_a = (n > DA);
    ovf_b = (n > DB);
    if (cut_line >= 0) begin
      ovf_a = 1'b0;
      ovf_b = 1'b0;
      err   = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge pclk);
    check("rst_we_a", 32'(if_a.we), 0);
    check("rst_we_b", 32'(if_b.we), 0);
    check("rst_busy_a", 32'(if_a.busy), 0);
    check("rst_addr_a", 32'(if_a.addr), 0);
    rst_n = 1'b1;
  endtask

  task automatic drive_frame(input int cut_line);
    int idx;
    idx = 0;
    @(negedge pclk);
    vsync = 1'b0;
    repeat (3) @(negedge pclk);
    for (int l = 0; l < ll.size(); l++) begin
      if (l == cut_line) do_reset();
      for (int b = 0; b < ll[l]; b++) begin
        @(negedge pclk);
        href = 1'b1;
        d    = fb[idx];
        idx++;
        if (abort_last && l == ll.size() - 1 && b == ll[l] - 1) vsync = 1'b1;
      end
      @(negedge pclk);
      href = 1'b0;
      d    = 8'h00;
      repeat (3) @(negedge pclk);
    end
    vsync = 1'b1;
    repeat (5) @(negedge pclk);
  endtask

  task automatic frame_check(input int fd0a, input int fd0b, input int exp_fd, input bit exp_busy,
                             input bit ovf_a, input bit ovf_b, input bit err);
    check("pending_a", 32'(qa.size()), 0);
    check("pending_b", 32'(qb.size()), 0);
    qa.delete();
    qb.delete();
    check("frame_done_a", 32'(fd_a - fd0a), 32'(exp_fd));
    check("frame_done_b", 32'(fd_b - fd0b), 32'(exp_fd));
    check("busy_a", 32'(if_a.busy), 32'(exp_busy));
    check("overflow_a", 32'(if_a.overflow), 32'(ovf_a));
    check("overflow_b", 32'(if_b.overflow), 32'(ovf_b));
    check("byte_err_a", 32'(if_a.byte_err), 32'(err));
    check("byte_err_b", 32'(if_b.byte_err), 32'(err));
  endtask

  task automatic run_frame(input int dec, input bit fm, input bit use_arm, input int cut_line,
                           input int exp_fd);
    bit oa, ob, er;
    int f0a, f0b;
    decim = 2'(dec);
    fmt   = fm;
    if (use_arm) begin
      @(negedge pclk);
      arm = 1'b1;
      @(negedge pclk);
      arm = 1'b0;
      repeat (2) @(negedge pclk);
    end
    f0a = fd_a;
    f0b = fd_b;
    model_frame(dec, fm, cut_line, oa, ob, er);
    drive_frame(cut_line);
    frame_check(f0a, f0b, exp_fd, continuous, oa, ob, er);
  endtask

  initial begin
    vsync      = 1'b1;
    href       = 1'b0;
    d          = 8'h00;
    arm        = 1'b0;
    continuous = 1'b0;
    decim      = 2'd0;
    fmt        = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge pclk);
    check("reset_addr", 32'(if_a.addr), 0);
    check("reset_dout", 32'(if_a.dout), 0);
    check("reset_we", 32'(if_a.we), 0);
    check("reset_busy", 32'(if_a.busy), 0);
    check("reset_frame_done", 32'(if_a.frame_done), 0);
    check("reset_overflow", 32'(if_a.overflow), 0);
    check("reset_byte_err", 32'(if_a.byte_err), 0);
    check("reset_busy_b", 32'(if_b.busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge pclk);
    check("idle_busy", 32'(if_a.busy), 0);

    // Full frame 1:1 RGB565, then 1:2, then RGB444 with a known first pixel.
    gen_frame(V, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b1, -1, 1);
    gen_frame(V, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b1, -1, 1);
    gen_frame(V, 1'b0, 1'b0);
    fb[0] = 8'hF8;
    fb[1] = 8'h1F;
    run_frame(0, 1'b1, 1'b1, -1, 1);
    check("rgb444_f8_1f", 32'(first_dout_a), 32'h0F0F);
    gen_frame(V, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b1, -1, 1);
    gen_frame(V, 1'b0, 1'b0);
    run_frame(3, 1'b1, 1'b1, -1, 1);

    // Odd line, over-long line and vsync rising in the middle of a line.
    ll.delete();
    ll.push_back(2 * H);
    ll.push_back(3);
    ll.push_back(2 * H + 2);
    ll.push_back(8);
    abort_last = 1'b1;
    fill_bytes();
    run_frame(0, 1'b0, 1'b1, -1, 1);

    // Randomised frames, including extra lines and malformed lengths.
    for (int i = 0; i < 6; i++) begin
      gen_frame($urandom_range(3, 5), 1'b1, 1'($urandom_range(0, 1)));
      run_frame($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, -1, 1);
    end

    // Continuous capture with a reset in the middle of the second frame.
    continuous = 1'b1;
    repeat (3) @(negedge pclk);
    gen_frame(V, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0, -1, 1);
    gen_frame(V, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0, 2, 0);
    gen_frame(V, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0, -1, 1);
    continuous = 1'b0;
    repeat (3) @(negedge pclk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard bound in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
